// File: rtl/bcd_serial_add_ctrl_pkg.sv
// rtl/bcd_serial_add_ctrl_pkg.sv - shared FSM encoding and BCD constants for the serial BCD adder
package bcd_serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// rtl/bcd_serial_add_ctrl_if.sv - start/busy/done handshake and operand/result bus (optional macro BCD_SUB_EN adds sub)
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
`ifdef BCD_SUB_EN
    logic                  sub;
`endif
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  carry_out;
    logic                  err;

    modport master (
        output start, a, b,
`ifdef BCD_SUB_EN
        output sub,
`endif
        input  busy, done, sum, carry_out, err
    );

    modport slave (
        input  start, a, b,
`ifdef BCD_SUB_EN
        input  sub,
`endif
        output busy, done, sum, carry_out, err
    );
endinterface

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// rtl/bcd_serial_add_ctrl_digit_add.sv - single-digit BCD add with decimal correction (module bcd_digit_add)
module bcd_digit_add
    import bcd_serial_add_ctrl_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       cin,
    output logic [3:0] s_d,
    output logic       cout,
    output logic       bad
);

    logic [4:0] t;

    // Binary add, then add 6 (mod 16) whenever the raw sum leaves the decimal range
    always_comb begin
        t    = {1'b0, a_d} + {1'b0, b_d} + {4'd0, cin};
        cout = (t > {1'b0, BCD_MAX});
        s_d  = cout ? (t[3:0] + BCD_CORR) : t[3:0];
        bad  = (a_d > BCD_MAX) | (b_d > BCD_MAX);
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed-BCD add controller, LSD first (optional macro BCD_SUB_EN)
module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_serial_add_ctrl_if.slave   bus
);

    localparam int W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;

    logic [3:0]         dig_b;
    logic [3:0]         dig_s;
    logic               dig_cout;
    logic               dig_bad;

`ifdef BCD_SUB_EN
    logic               sub_q, sub_d;

    // Subtraction feeds the nines complement of B; an out-of-range B digit
    // still lands outside 0..9 after complementing, so the adder's bad flag
    // reflects the original B digit.
    assign dig_b = sub_q ? (BCD_MAX - b_q[3:0]) : b_q[3:0];
`else
    assign dig_b = b_q[3:0];
`endif

    bcd_digit_add u_digit_add (
        .a_d  (a_q[3:0]),
        .b_d  (dig_b),
        .cin  (carry_q),
        .s_d  (dig_s),
        .cout (dig_cout),
        .bad  (dig_bad)
    );

    // Next-state and datapath sequencing: capture in IDLE, one digit per ADD cycle, publish in FIN
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        err_d   = err_q;
`ifdef BCD_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sum_d   = '0;
                    cnt_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
`ifdef BCD_SUB_EN
                    sub_d   = bus.sub;
                    carry_d = bus.sub;
`else
                    carry_d = 1'b0;
`endif
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                sum_d   = {dig_s, sum_q[W-1:4]};
                a_d     = {4'd0, a_q[W-1:4]};
                b_d     = {4'd0, b_q[W-1:4]};
                carry_d = dig_cout;
                err_d   = err_q | dig_bad;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                cout_d  = carry_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BCD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
`ifdef BCD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - randomized self-checking bench for bcd_serial_add_ctrl (honours BCD_SUB_EN)
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] r = '0;
        int           x = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit all_valid(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: decimal arithmetic for valid operands, the per-digit
    // t>9 -> t+6 mod 16 rule only when some digit is out of range.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                         output logic [W-1:0] s, output bit c, output bit e);
        int m;
        int n;
        int cy;
        int ad;
        int bd;
        int t;
        m = 1;
        for (int i = 0; i < DIGITS; i++) m = m * 10;
        e = !(all_valid(a) && all_valid(b));
        s = '0;
        if (!e) begin
            if (!sub) begin
                n = bcd2int(a) + bcd2int(b);
                c = (n >= m);
                s = int2bcd(n % m);
            end else begin
                n = bcd2int(a) - bcd2int(b);
                c = (n >= 0);
                s = int2bcd(n < 0 ? n + m : n);
            end
        end else begin
            cy = sub ? 1 : 0;
            for (int i = 0; i < DIGITS; i++) begin
                ad = int'(a[4*i +: 4]);
                bd = int'(b[4*i +: 4]);
                if (sub) bd = (9 - bd) & 15;
                t = ad + bd + cy;
                if (t > 9) begin
                    s[4*i +: 4] = 4'((t + 6) % 16);
                    cy = 1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    cy = 0;
                end
            end
            c = (cy != 0);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the start edge
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    // poke=k (1..5) raises a stray start with fresh operands k-1 cycles after launch
    task automatic wait_done(input int poke, output int edges, output int busy_cnt);
        check("done_single_pulse", bus.done, 1'b0);
        edges    = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && edges < 40) begin
            bus.start = (poke != 0) && (edges == poke - 1);
            if (bus.start) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
            end
            @(negedge clk);
            edges++;
            if (bus.busy) busy_cnt++;
        end
        bus.start = 1'b0;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub, input int poke);
        logic [W-1:0] es;
        bit           ec;
        bit           ee;
        int           ed;
        int           bc;
        model(a, b, sub, es, ec, ee);
`ifdef BCD_SUB_EN
        bus.sub = sub;
`endif
        launch(a, b);
        wait_done(poke, ed, bc);
        check("latency", ed, DIGITS + 1);
        check("busy_cycles", bc, DIGITS + 1);
        check("sum", bus.sum, es);
        check("carry_out", bus.carry_out, ec);
        check("err", bus.err, ee);
    endtask

    function automatic logic [3:0] rand_digit(input bit allow_bad);
        if (allow_bad && $urandom_range(0, 3) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           rs;
        bit           inval;
        int           rpoke;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef BCD_SUB_EN
        bus.sub   = 1'b0;
`endif
        #1 rst = 1'b1;
        #2;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_sum", bus.sum, 16'h0000);
        check("rst_carry_out", bus.carry_out, 1'b0);
        check("rst_err", bus.err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'h0199, 16'h0001, 1'b0, 0);
        check("tp1_sum", bus.sum, 16'h0200);
        check("tp1_cout", bus.carry_out, 1'b0);
        check("tp1_err", bus.err, 1'b0);
        @(negedge clk);

        do_op(16'h9999, 16'h0001, 1'b0, 0);
        check("wrap_sum", bus.sum, 16'h0000);
        check("wrap_cout", bus.carry_out, 1'b1);
        do_op(16'h4567, 16'h4321, 1'b0, 0);
        check("b2b_sum", bus.sum, 16'h8888);
        check("b2b_cout", bus.carry_out, 1'b0);

        do_op(16'h1234, 16'h5678, 1'b0, 2);
        check("poke_add_sum", bus.sum, 16'h6912);
        do_op(16'h2500, 16'h2500, 1'b0, 5);
        check("poke_fin_sum", bus.sum, 16'h5000);

        do_op(16'h00A0, 16'h0000, 1'b0, 0);
        check("bad_err", bus.err, 1'b1);
        check("bad_sum", bus.sum, 16'h0100);
        @(negedge clk);
        check("err_held_idle", bus.err, 1'b1);
        do_op(16'h0001, 16'h0002, 1'b0, 0);
        check("err_cleared", bus.err, 1'b0);
        check("err_cleared_sum", bus.sum, 16'h0003);

        @(negedge clk);
        launch(16'h1234, 16'h1111);
        @(negedge clk);
        @(negedge clk);
        check("sum_partial", bus.sum, 16'h4500);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", bus.busy, 1'b0);
        check("async_rst_sum", bus.sum, 16'h0000);
        check("async_rst_done", bus.done, 1'b0);
        check("async_rst_err", bus.err, 1'b0);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_done_after_rst", bus.done, 1'b0);
            check("idle_after_rst", bus.busy, 1'b0);
        end
        do_op(16'h0042, 16'h0058, 1'b0, 0);
        check("post_rst_sum", bus.sum, 16'h0100);

`ifdef BCD_SUB_EN
        @(negedge clk);
        do_op(16'h0100, 16'h0001, 1'b1, 0);
        check("sub_sum", bus.sum, 16'h0099);
        check("sub_cout", bus.carry_out, 1'b1);
        do_op(16'h0000, 16'h0001, 1'b1, 0);
        check("sub_borrow_sum", bus.sum, 16'h9999);
        check("sub_borrow_cout", bus.carry_out, 1'b0);
`endif

        for (int n = 0; n < 60; n++) begin
            inval = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < DIGITS; i++) begin
                ra[4*i +: 4] = rand_digit(inval);
                rb[4*i +: 4] = rand_digit(inval);
            end
`ifdef BCD_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            rpoke = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            do_op(ra, rb, rs, rpoke);
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("final_idle_busy", bus.busy, 1'b0);
            check("final_idle_done", bus.done, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
Digit-serial controller that adds two multi-digit packed-BCD operands using one shared single-digit BCD adder stage, one digit per clock, LSD first.
Sits above the 4-bit BCD add/correct datapath and sequences it through DIGITS iterations, propagating the decimal carry between digits.
Provides a start/busy/done handshake toward the surrounding control logic.

Parameters:
DIGITS, 4, number of BCD digits per operand (legal 2..8)
CNT_W, 3, digit-counter width; must satisfy 2**CNT_W >= DIGITS

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  4*DIGITS  packed BCD operand A, digit 0 in bits [3:0]
b  input  4*DIGITS  packed BCD operand B
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when sum is valid
sum  output  4*DIGITS  packed BCD result; held until next accepted start
carry_out  output  1  decimal carry out of the most significant digit
err  output  1  sticky: some input digit was >9 during the current operation

Behaviour:
- Reset: asynchronous, active-high; takes effect immediately regardless of clk. State=IDLE; busy=0, done=0, sum=0, carry_out=0, err=0; operand registers, carry and counter cleared.
- Reset asserted mid-operation: operation is abandoned, no done pulse, all outputs return to reset values.
- FSM states: IDLE, ADD, FIN.
- IDLE: start=1 at edge -> capture a and b into shift registers, clear carry, counter, sum and err; busy=1; go to ADD.
- ADD, one digit per cycle:
  - Binary sum t = a_d + b_d + carry (5 bits).
  - If t>9: digit = t+6 mod 16, carry=1; else digit = t, carry=0.
  - Digit is shifted into sum from the MSD side. Operand registers shift right by 4.
  - err |= (a_d>9) | (b_d>9). The invalid digit is still processed by the same rule.
  - Counter==DIGITS-1 -> go to FIN.
- FIN: carry_out=carry, busy=0, done=1 for exactly this cycle; go to IDLE.
- Latency: start sampled at edge 0 -> done high in the cycle following edge DIGITS+1 (5 edges for DIGITS=4). Back-to-back operations are legal: start may be asserted on the cycle done is high (state is IDLE next cycle) and is sampled on the next edge.
- start while busy or in FIN: ignored; operands not recaptured.
- a/b changes after capture: no effect on the current operation.
- sum, carry_out and err keep their values in IDLE until the next accepted start.
- Wrap-around: 9..9 + 0..1 -> sum=0, carry_out=1.

Optional Feature:
BCD_SUB_EN
- Defined: adds input port sub (1 bit), captured with the operands at start. When sub=1:
  - b digits are replaced by their nines complement (9-b_d).
  - Initial carry=1, so the result is A-B mod 10^DIGITS.
  - carry_out=1 means no borrow (A>=B); carry_out=0 means borrow.
  - err is checked on the original b digits, before complementing.
- Undefined: no sub port; addition only.

Decomposition:
- Shared include bcd_defs.vh holds:
  - FSM state encodings S_IDLE=2'd0, S_ADD=2'd1, S_FIN=2'd2
  - BCD_MAX=4'd9
  - BCD_CORR=4'd6
- One sub-module: bcd_digit_add (combinational). Inputs a_d[3:0], b_d[3:0], cin; outputs s_d[3:0], cout, bad.
- The controller instantiates one bcd_digit_add and owns the FSM, counter, shift registers and flags.

Test Plan:
- Reset then start, a=16'h0199, b=16'h0001 -> busy high 5 cycles; done pulse on 5th edge; sum=16'h0200, carry_out=0, err=0.
- a=16'h9999, b=16'h0001 -> sum=16'h0000, carry_out=1; then a=16'h4567, b=16'h4321 back-to-back -> sum=16'h8888, carry_out=0.
- start re-pulsed with new operands during ADD -> ignored; only one done pulse; sum reflects the first operands.
- a=16'h00A0, b=16'h0000 -> err=1 at done; err cleared on the next start with valid operands.
- rst asserted asynchronously (between edges) during the 3rd ADD cycle -> busy=0, sum=0 immediately; no done pulse; the next operation completes correctly.
- BCD_SUB_EN defined, sub=1: a=16'h0100, b=16'h0001 -> sum=16'h0099, carry_out=1; a=16'h0000, b=16'h0001 -> sum=16'h9999, carry_out=0.
